// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package period_meter_pkg;

  // Default width of the period counter and of the measured result.
  localparam int PM_WIDTH_DEFAULT = 28;

  // IDLE waits for the pulse that starts a period; MEASURE counts it.
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } pm_state_t;

endpackage

// File: rtl/period_counter.sv
// Free-running period counter with synchronous load-zero and an all-ones flag.
// Latency: count changes on the clock edge after load_zero/incr; terminal is combinational.
// Backpressure: none; load_zero wins over incr.
module period_counter
  import period_meter_pkg::*;
#(
  parameter int WIDTH = PM_WIDTH_DEFAULT
) (
  input  logic             clock_in,
  input  logic             resetn,
  input  logic             load_zero,
  input  logic             incr,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Restart from zero or advance by one cycle of elapsed period.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load_zero) begin
      count <= '0;
    end else if (incr) begin
      count <= count + ONE;
    end
  end

  // All-ones: one more non-pulse cycle would exceed the representable period.
  assign terminal = &count;

endmodule

// File: rtl/period_meter.sv
// Measures cycles between pulse_in strobes; rate_out = cycles-between-pulses minus 1.
// Latency: rate_out/valid/sample update one cycle after the closing pulse; clear takes effect next edge.
// Backpressure: none; optional lock detector enabled by defining PERIOD_METER_LOCK_EN.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH      = PM_WIDTH_DEFAULT,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clock_in,
  input  logic             resetn,
  input  logic             pulse_in,
  input  logic             clear,
  output logic [WIDTH-1:0] rate_out,
  output logic             valid,
  output logic             sample,
  output logic             overflow,
  output logic             locked
);

  pm_state_t        state;
  pm_state_t        state_nxt;
  logic             cnt_load;
  logic             cnt_incr;
  logic             capture;
  logic             ovf_hit;
  logic [WIDTH-1:0] count;
  logic             terminal;

  period_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clock_in (clock_in),
    .resetn   (resetn),
    .load_zero(cnt_load),
    .incr     (cnt_incr),
    .count    (count),
    .terminal (terminal)
  );

  // State register.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and counter/result control; clear overrides any pulse.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_incr  = 1'b0;
    capture   = 1'b0;
    ovf_hit   = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      cnt_load  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pulse_in) begin
            state_nxt = MEASURE;
            cnt_load  = 1'b1;
          end
        end
        MEASURE: begin
          if (pulse_in) begin
            // A pulse on the all-ones count is still a valid measurement.
            capture  = 1'b1;
            cnt_load = 1'b1;
          end else if (terminal) begin
            state_nxt = IDLE;
            cnt_load  = 1'b1;
            ovf_hit   = 1'b1;
          end else begin
            cnt_incr = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_load  = 1'b1;
        end
      endcase
    end
  end

  // Result registers; rate_out and overflow survive clear, overflow is sticky.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      rate_out <= '0;
      valid    <= 1'b0;
      sample   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sample <= capture;
      if (capture) begin
        rate_out <= count;
        valid    <= 1'b1;
      end
      if (clear || ovf_hit) begin
        valid <= 1'b0;
      end
      if (ovf_hit) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef PERIOD_METER_LOCK_EN
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_COUNT);
  localparam logic [MW-1:0] MATCH_THR = MW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0] MATCH_ONE = MW'(1);

  logic [MW-1:0] match_cnt;
  logic [MW-1:0] match_nxt;

  // Match count after this capture; the first measurement after IDLE has no
  // previous result (valid low) and so counts as a mismatch.
  always_comb begin
    match_nxt = match_cnt;
    if (capture) begin
      if (valid && (count == rate_out)) begin
        match_nxt = (match_cnt >= MATCH_MAX) ? match_cnt : match_cnt + MATCH_ONE;
      end else begin
        match_nxt = '0;
      end
    end
  end

  // Lock state follows the match count, updated together with sample.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      match_cnt <= '0;
      locked    <= 1'b0;
    end else if (clear || ovf_hit) begin
      match_cnt <= '0;
      locked    <= 1'b0;
    end else if (capture) begin
      match_cnt <= match_nxt;
      locked    <= (match_nxt >= MATCH_THR);
    end
  end
`else
  // Lock detection not built: report never locked.
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: pulse-train table, clear/reset/overflow/lock corners.
// Latency: n/a.
// Backpressure: n/a.
module tb_period_meter;

  localparam int W  = 28;
  localparam int LC = 4;

  logic          clock_in = 1'b0;
  logic          resetn;
  logic          pulse_a, clear_a, pulse_b, clear_b;
  logic [W-1:0]  rate_a;
  logic          valid_a, sample_a, ovf_a, lock_a;
  logic [3:0]    rate_b;
  logic          valid_b, sample_b, ovf_b, lock_b;

  period_meter #(.WIDTH(W), .LOCK_COUNT(LC)) dut_a (
    .clock_in(clock_in), .resetn(resetn), .pulse_in(pulse_a), .clear(clear_a),
    .rate_out(rate_a), .valid(valid_a), .sample(sample_a), .overflow(ovf_a), .locked(lock_a)
  );

  period_meter #(.WIDTH(4), .LOCK_COUNT(LC)) dut_b (
    .clock_in(clock_in), .resetn(resetn), .pulse_in(pulse_b), .clear(clear_b),
    .rate_out(rate_b), .valid(valid_b), .sample(sample_b), .overflow(ovf_b), .locked(lock_b)
  );

  always #5 clock_in = ~clock_in;

  typedef struct { int rate; bit lock; } exp_t;
  typedef struct { int period; int count; int exp_rate; int exp_samples; } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   per[$];

  // Observed samples, recorded on the falling edge by per-DUT monitors.
  int obs_rate_a[256];
  bit obs_lock_a[256];
  int obs_n_a = 0;
  int obs_rate_b[256];
  bit obs_lock_b[256];
  int obs_n_b = 0;
  int rd_a = 0;
  int rd_b = 0;

  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clock_in) begin
    if (sample_a === 1'b1 && obs_n_a < 256) begin
      obs_rate_a[obs_n_a] = int'(rate_a);
      obs_lock_a[obs_n_a] = lock_a;
      obs_n_a = obs_n_a + 1;
    end
  end

  always @(negedge clock_in) begin
    if (sample_b === 1'b1 && obs_n_b < 256) begin
      obs_rate_b[obs_n_b] = int'(rate_b);
      obs_lock_b[obs_n_b] = lock_b;
      obs_n_b = obs_n_b + 1;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clock_in);
      #1;
    end
  endtask

  task automatic fire(input bit sel);
    if (sel) pulse_b = 1'b1;
    else     pulse_a = 1'b1;
    @(posedge clock_in);
    #1;
    pulse_a = 1'b0;
    pulse_b = 1'b0;
  endtask

  task automatic clr(input bit sel);
    if (sel) clear_b = 1'b1;
    else     clear_a = 1'b1;
    @(posedge clock_in);
    #1;
    clear_a = 1'b0;
    clear_b = 1'b0;
  endtask

  task automatic mk(input int p, input int n);
    repeat (n) per.push_back(p);
  endtask

  // Opening pulse, then one pulse per entry of per; each closing pulse
  // pushes its expected rate and lock (locked once LC equal results in a row).
  task automatic run_seq(input bit sel);
    int   prev;
    int   run;
    exp_t e;
    prev = -1;
    run  = 0;
    fire(sel);
    foreach (per[i]) begin
      idle(per[i] - 1);
      run  = (per[i] - 1 == prev) ? run + 1 : 1;
      prev = per[i] - 1;
      e.rate = per[i] - 1;
`ifdef PERIOD_METER_LOCK_EN
      e.lock = (run >= LC);
`else
      e.lock = 1'b0;
`endif
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
      fire(sel);
    end
    per.delete();
  endtask

  task automatic drain(input bit sel, input string nm);
    exp_t e;
    int   r;
    bit   l;
    while ((sel ? q_b.size() : q_a.size()) != 0) begin
      r = -1;
      l = 1'b0;
      if (sel) begin
        e = q_b.pop_front();
        if (rd_b < obs_n_b) begin r = obs_rate_b[rd_b]; l = obs_lock_b[rd_b]; rd_b++; end
      end else begin
        e = q_a.pop_front();
        if (rd_a < obs_n_a) begin r = obs_rate_a[rd_a]; l = obs_lock_a[rd_a]; rd_a++; end
      end
      chk({nm, " rate"}, r, e.rate);
      chk({nm, " locked"}, l, e.lock);
    end
    chk({nm, " extra samples"}, sel ? obs_n_b - rd_b : obs_n_a - rd_a, 0);
    rd_a = obs_n_a;
    rd_b = obs_n_b;
  endtask

  vec_t tbl[5];
  int   s;

  initial begin
    tbl[0] = '{10, 5, 9, 4};
    tbl[1] = '{1, 6, 0, 5};
    tbl[2] = '{3, 4, 2, 3};
    tbl[3] = '{2, 3, 1, 2};
    tbl[4] = '{7, 3, 6, 2};

    resetn = 1'b0; pulse_a = 1'b0; clear_a = 1'b0; pulse_b = 1'b0; clear_b = 1'b0;
    @(posedge clock_in);
    #1;
    chk("reset rate_out", rate_a, 0);
    chk("reset valid", valid_a, 0);
    chk("reset sample", sample_a, 0);
    chk("reset overflow", ovf_a, 0);
    chk("reset locked", lock_a, 0);
    chk("reset overflow w4", ovf_b, 0);
    chk("reset valid w4", valid_b, 0);
    resetn = 1'b1;
    idle(1);

    // Regular pulse trains, restarted with clear between entries.
    for (int i = 0; i < 5; i++) begin
      s = obs_n_a;
      mk(tbl[i].period, tbl[i].count - 1);
      run_seq(1'b0);
      idle(2);
      chk($sformatf("train%0d sample count", i), obs_n_a - s, tbl[i].exp_samples);
      drain(1'b0, $sformatf("train%0d", i));
      chk($sformatf("train%0d valid", i), valid_a, 1);
      chk($sformatf("train%0d rate_out", i), rate_a, tbl[i].exp_rate);
      chk($sformatf("train%0d overflow", i), ovf_a, 0);
      clr(1'b0);
      chk($sformatf("train%0d clr valid", i), valid_a, 0);
      chk($sformatf("train%0d clr rate held", i), rate_a, tbl[i].exp_rate);
      chk($sformatf("train%0d clr locked", i), lock_a, 0);
    end

    // clear together with pulse mid-stream: clear wins, result held.
    mk(10, 2);
    run_seq(1'b0);
    idle(4);
    drain(1'b0, "pre-clear");
    clear_a = 1'b1;
    pulse_a = 1'b1;
    @(posedge clock_in);
    #1;
    clear_a = 1'b0;
    pulse_a = 1'b0;
    chk("clear+pulse valid", valid_a, 0);
    chk("clear+pulse sample", sample_a, 0);
    chk("clear+pulse rate held", rate_a, 9);
    chk("clear+pulse locked", lock_a, 0);
    s = obs_n_a;
    idle(3);
    chk("no sample after clear", obs_n_a - s, 0);
    mk(5, 1);
    run_seq(1'b0);
    idle(2);
    drain(1'b0, "after clear");
    clr(1'b0);

    // Lock sequence: five periods of 8 then one of 9.
    mk(8, 5);
    per.push_back(9);
    run_seq(1'b0);
    idle(2);
    drain(1'b0, "lock seq");
    chk("lock seq final rate", rate_a, 8);
    chk("lock seq final locked", lock_a, 0);
    clr(1'b0);

    // Overflow on the 4-bit meter, then an exact 16-cycle period.
    fire(1'b1);
    idle(20);
    chk("w4 overflow set", ovf_b, 1);
    chk("w4 overflow valid", valid_b, 0);
    chk("w4 overflow locked", lock_b, 0);
    chk("w4 overflow no sample", obs_n_b, 0);
    mk(16, 3);
    run_seq(1'b1);
    idle(2);
    drain(1'b1, "w4 period16");
    chk("w4 rate_out all ones", rate_b, 15);
    chk("w4 overflow sticky", ovf_b, 1);
    chk("w4 valid", valid_b, 1);

    // Asynchronous reset in the middle of a period.
    mk(10, 2);
    run_seq(1'b0);
    idle(3);
    drain(1'b0, "pre-reset");
    #2;
    resetn = 1'b0;
    #1;
    chk("async reset rate_out", rate_a, 0);
    chk("async reset valid", valid_a, 0);
    chk("async reset sample", sample_a, 0);
    chk("async reset locked", lock_a, 0);
    chk("async reset overflow w4", ovf_b, 0);
    chk("async reset rate w4", rate_b, 0);
    @(posedge clock_in);
    #1;
    resetn = 1'b1;
    mk(6, 1);
    run_seq(1'b0);
    idle(2);
    drain(1'b0, "after reset");
    chk("after reset valid", valid_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
